// File: rtl/reset_sequencer.sv
// Staggered multi-domain reset sequencer: stretch all domain resets, then release them low-bit first.
// Optional watchdog (wdt_kick/wdt_bite) is built only when RESET_SEQ_WDT_EN is defined.
module reset_sequencer #(
    parameter int NUM_DOMAINS = 4,
    parameter int STRETCH     = 16,
    parameter int STAGGER     = 4,
    parameter int CNT_W       = 8,
    parameter int WDT_CYCLES  = 200
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   soft_req,
`ifdef RESET_SEQ_WDT_EN
    input  logic                   wdt_kick,
    output logic                   wdt_bite,
`endif
    output logic [NUM_DOMAINS-1:0] domain_rst,
    output logic                   ready,
    output logic [1:0]             seq_state
);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'b00,
        ST_STRETCH = 2'b01,
        ST_RELEASE = 2'b10,
        ST_RUN     = 2'b11
    } state_e;

    localparam int MAX_CNT = (STRETCH > STAGGER) ?
                             ((STRETCH > WDT_CYCLES) ? STRETCH : WDT_CYCLES) :
                             ((STAGGER > WDT_CYCLES) ? STAGGER : WDT_CYCLES);

    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER - 1);

    generate
        if (NUM_DOMAINS < 1 || STRETCH < 1 || STAGGER < 0 || (MAX_CNT >> CNT_W) != 0) begin : g_bad_cfg
            $error("reset_sequencer: invalid parameter set");
        end
    endgenerate

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       stg_q, stg_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic                   ready_q, ready_d;
    logic [NUM_DOMAINS-1:0] dom_shift;
    logic                   wdt_fire;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            stg_q   <= '0;
            dom_q   <= '1;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stg_q   <= stg_d;
            dom_q   <= dom_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stg_d     = stg_q;
        dom_d     = dom_q;
        ready_d   = ready_q;
        // Thermometer release: one more low bit drops to 0 per step.
        dom_shift = dom_q << 1;

        if (state_q != ST_HOLD && (soft_req || wdt_fire)) begin
            state_d = ST_STRETCH;
            cnt_d   = CNT_ONE;
            stg_d   = '0;
            dom_d   = '1;
            ready_d = 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    state_d = ST_STRETCH;
                    cnt_d   = CNT_ONE;
                end
                ST_STRETCH: begin
                    if (cnt_q >= STRETCH_LAST) begin
                        cnt_d = '0;
                        stg_d = '0;
                        if (STAGGER == 0 || NUM_DOMAINS == 1) begin
                            dom_d   = '0;
                            ready_d = 1'b1;
                            state_d = ST_RUN;
                        end else begin
                            dom_d   = dom_shift;
                            state_d = ST_RELEASE;
                        end
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
                ST_RELEASE: begin
                    if (stg_q >= STAGGER_LAST) begin
                        stg_d = '0;
                        dom_d = dom_shift;
                        if (dom_shift == '0) begin
                            ready_d = 1'b1;
                            state_d = ST_RUN;
                        end
                    end else begin
                        stg_d = sat_inc(stg_q);
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_HOLD;
                end
            endcase
        end
    end

`ifdef RESET_SEQ_WDT_EN
    localparam logic [CNT_W-1:0] WDT_LAST = CNT_W'(WDT_CYCLES - 1);

    logic [CNT_W-1:0] wdt_q, wdt_d;
    logic             bite_q;

    // Counter is held at zero outside RUN, so entry to RUN always starts a fresh timeout.
    always_comb begin
        wdt_d    = '0;
        wdt_fire = 1'b0;
        if (state_q == ST_RUN && !wdt_kick) begin
            if (wdt_q >= WDT_LAST) begin
                wdt_fire = 1'b1;
            end else begin
                wdt_d = sat_inc(wdt_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wdt_q  <= '0;
            bite_q <= 1'b0;
        end else begin
            wdt_q  <= wdt_d;
            bite_q <= wdt_fire;
        end
    end

    assign wdt_bite = bite_q;
`else
    assign wdt_fire = 1'b0;
`endif

    assign domain_rst = dom_q;
    assign ready      = ready_q;
    assign seq_state  = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: three parameter sets share rst/soft_req; a monitor checks queued expectations.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       soft_req;
    int         cyc = 0;

    logic [3:0] dom_main, dom_stg0;
    logic [0:0] dom_one;
    logic       rdy_main, rdy_stg0, rdy_one;
    logic [1:0] st_main, st_stg0, st_one;
`ifdef RESET_SEQ_WDT_EN
    logic       wdt_kick;
    logic       bite_main, bite_stg0, bite_one;
`endif

    typedef struct {
        int         cyc;
        int         inst;   // 0 main, 1 stagger0, 2 single domain, 3 watchdog bites
        logic [3:0] dom;
        logic       rdy;
        logic [1:0] st;
        logic       bite;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reset_sequencer #(.NUM_DOMAINS(4), .STRETCH(16), .STAGGER(4), .CNT_W(8), .WDT_CYCLES(200)) u_main (
        .clk(clk), .rst(rst), .soft_req(soft_req),
`ifdef RESET_SEQ_WDT_EN
        .wdt_kick(wdt_kick), .wdt_bite(bite_main),
`endif
        .domain_rst(dom_main), .ready(rdy_main), .seq_state(st_main));

    reset_sequencer #(.NUM_DOMAINS(4), .STRETCH(16), .STAGGER(0), .CNT_W(8), .WDT_CYCLES(200)) u_stg0 (
        .clk(clk), .rst(rst), .soft_req(soft_req),
`ifdef RESET_SEQ_WDT_EN
        .wdt_kick(wdt_kick), .wdt_bite(bite_stg0),
`endif
        .domain_rst(dom_stg0), .ready(rdy_stg0), .seq_state(st_stg0));

    reset_sequencer #(.NUM_DOMAINS(1), .STRETCH(1), .STAGGER(4), .CNT_W(8), .WDT_CYCLES(200)) u_one (
        .clk(clk), .rst(rst), .soft_req(soft_req),
`ifdef RESET_SEQ_WDT_EN
        .wdt_kick(wdt_kick), .wdt_bite(bite_one),
`endif
        .domain_rst(dom_one), .ready(rdy_one), .seq_state(st_one));

    task automatic push(input int c, input int inst, input logic [3:0] d, input logic r,
                        input logic [1:0] s, input logic b);
        exp_t e;
        e.cyc = c; e.inst = inst; e.dom = d; e.rdy = r; e.st = s; e.bite = b;
        sb.push_back(e);
    endtask

    task automatic push_hold(input int c);
        push(c, 0, 4'b1111, 1'b0, 2'b00, 1'b0);
        push(c, 1, 4'b1111, 1'b0, 2'b00, 1'b0);
        push(c, 2, 4'b0001, 1'b0, 2'b00, 1'b0);
    endtask

    // Full release schedule for a sequence whose STRETCH starts at edge e; offsets beyond upto are skipped.
    task automatic push_seq(input int e, input int upto);
        if (upto >= 0)  push(e,      0, 4'b1111, 1'b0, 2'b01, 1'b0);
        if (upto >= 15) push(e + 15, 0, 4'b1111, 1'b0, 2'b01, 1'b0);
        if (upto >= 16) push(e + 16, 0, 4'b1110, 1'b0, 2'b10, 1'b0);
        if (upto >= 19) push(e + 19, 0, 4'b1110, 1'b0, 2'b10, 1'b0);
        if (upto >= 20) push(e + 20, 0, 4'b1100, 1'b0, 2'b10, 1'b0);
        if (upto >= 24) push(e + 24, 0, 4'b1000, 1'b0, 2'b10, 1'b0);
        if (upto >= 27) push(e + 27, 0, 4'b1000, 1'b0, 2'b10, 1'b0);
        if (upto >= 28) push(e + 28, 0, 4'b0000, 1'b1, 2'b11, 1'b0);
        if (upto >= 15) push(e + 15, 1, 4'b1111, 1'b0, 2'b01, 1'b0);
        if (upto >= 16) push(e + 16, 1, 4'b0000, 1'b1, 2'b11, 1'b0);
        if (upto >= 0)  push(e,      2, 4'b0001, 1'b0, 2'b01, 1'b0);
        if (upto >= 1)  push(e + 1,  2, 4'b0000, 1'b1, 2'b11, 1'b0);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check(input exp_t e);
        logic [6:0] got, want;
        string      nm;
        want = {e.dom, e.rdy, e.st};
        got  = '0;
        nm   = "unknown";
        case (e.inst)
            0: begin got = {dom_main, rdy_main, st_main};          nm = "main"; end
            1: begin got = {dom_stg0, rdy_stg0, st_stg0};          nm = "stagger0"; end
            2: begin got = {3'b000, dom_one, rdy_one, st_one};     nm = "single"; end
`ifdef RESET_SEQ_WDT_EN
            3: begin
                got  = {4'b0000, bite_main, bite_stg0, bite_one};
                want = {4'b0000, e.bite, e.bite, e.bite};
                nm   = "wdt_bite";
            end
`endif
            default: ;
        endcase
        n_vec++;
        if (e.cyc != cyc) begin
            n_err++;
            $display("FAIL %s stale expectation for edge %0d seen at edge %0d", nm, e.cyc, cyc);
        end else if (got !== want) begin
            n_err++;
            $display("FAIL %s edge %0d got {dom,rdy,st}=%b required %b", nm, cyc, got, want);
        end
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                check(sb[i]);
                sb.delete(i);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout at edge %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int c, e, f, g, s, l;
`ifdef RESET_SEQ_WDT_EN
        int k0, k1, k2, k3;
        wdt_kick = 1'b1;
`endif
        rst      = 1'b0;
        soft_req = 1'b0;
        push_hold(2);
        push_hold(3);

        // Power-on: rst released so that edge 4 is the first with rst high.
        wait_cyc(3);
        rst = 1'b1;
        e = cyc + 1;
        push_seq(e, 99);
        wait_cyc(e + 30);

        // Reset in RUN, then again mid-release at F+22, then a full restart.
        c = cyc;
        rst = 1'b0;
        push_hold(c + 1);
        wait_cyc(c + 1);
        rst = 1'b1;
        f = c + 2;
        push_seq(f, 21);
        push(f + 21, 0, 4'b1100, 1'b0, 2'b10, 1'b0);
        wait_cyc(f + 21);
        rst = 1'b0;
        push_hold(f + 22);
        wait_cyc(f + 22);
        rst = 1'b1;
        g = f + 23;
        push_seq(g, 99);
        wait_cyc(g + 30);

        // One-cycle soft request in RUN.
        s = cyc + 1;
        soft_req = 1'b1;
        push_seq(s, 99);
        wait_cyc(s);
        soft_req = 1'b0;
        wait_cyc(s + 30);

        // rst low beats soft_req; then soft_req held for 10 edges after rst release.
        c = cyc;
        rst = 1'b0;
        soft_req = 1'b1;
        push_hold(c + 1);
        wait_cyc(c + 1);
        rst = 1'b1;
        e = c + 2;
        l = e + 9;
        push(e,     0, 4'b1111, 1'b0, 2'b01, 1'b0);
        push(e + 5, 0, 4'b1111, 1'b0, 2'b01, 1'b0);
        push(e + 5, 2, 4'b0001, 1'b0, 2'b01, 1'b0);
        push_seq(l, 99);
        wait_cyc(l);
        soft_req = 1'b0;
        wait_cyc(l + 30);

`ifdef RESET_SEQ_WDT_EN
        // Watchdog: kick after 150, kick exactly on the timeout edge, then starve it.
        k0 = cyc;
        wdt_kick = 1'b0;
        k1 = k0 + 150;
        push(k0 + 149, 3, 4'b0000, 1'b0, 2'b00, 1'b0);
        push(k1,       3, 4'b0000, 1'b0, 2'b00, 1'b0);
        push(k1 + 1,   3, 4'b0000, 1'b0, 2'b00, 1'b0);
        wait_cyc(k1 - 1);
        wdt_kick = 1'b1;
        wait_cyc(k1);
        wdt_kick = 1'b0;
        k2 = k1 + 200;
        push(k2,     3, 4'b0000, 1'b0, 2'b00, 1'b0);
        push(k2 + 1, 3, 4'b0000, 1'b0, 2'b00, 1'b0);
        push(k2,     0, 4'b0000, 1'b1, 2'b11, 1'b0);
        push(k2 + 1, 0, 4'b0000, 1'b1, 2'b11, 1'b0);
        wait_cyc(k2 - 1);
        wdt_kick = 1'b1;
        wait_cyc(k2);
        wdt_kick = 1'b0;
        k3 = k2 + 200;
        push(k3 - 1, 3, 4'b0000, 1'b0, 2'b00, 1'b0);
        push(k3,     3, 4'b0000, 1'b0, 2'b00, 1'b1);
        push(k3 + 1, 3, 4'b0000, 1'b0, 2'b00, 1'b0);
        push(k3 - 1, 0, 4'b0000, 1'b1, 2'b11, 1'b0);
        push_seq(k3, 99);
        wait_cyc(k3 + 30);
        wdt_kick = 1'b1;
`endif

        wait_cyc(cyc + 3);
        foreach (sb[i]) begin
            n_vec++;
            n_err++;
            $display("FAIL unchecked expectation inst %0d edge %0d", sb[i].inst, sb[i].cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
